// File: rtl/bcd_mod_counter_7seg.sv
// Two-digit BCD modulo counter with prescaler, up/down stepping, validated load
// and dual 7-segment decode of the registered digits.
module bcd_mod_counter_7seg #(
  parameter int unsigned MODULUS        = 60,
  parameter int unsigned PRESCALE       = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable_n,
  input  logic       up,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry,
  output logic       load_err,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_units
);

  localparam int unsigned     PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [3:0]      MAX_TENS  = 4'((MODULUS - 1) / 10);
  localparam logic [3:0]      MAX_UNITS = 4'((MODULUS - 1) % 10);
  localparam logic [7:0]      MOD_VAL   = 8'(MODULUS);

  // Reject illegal configurations at elaboration
  generate
    if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
      $error("bcd_mod_counter_7seg: MODULUS must be in 2..100");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("bcd_mod_counter_7seg: PRESCALE must be >= 1");
    end
  endgenerate

  logic [PRE_W-1:0] prescale;
  logic [3:0]       step_tens;
  logic [3:0]       step_units;
  logic             step_wrap;
  logic [7:0]       load_value;
  logic             load_valid;

  // Next digits for one up/down step, with wrap/borrow detection
  always_comb begin
    step_tens  = tens;
    step_units = units;
    step_wrap  = 1'b0;
    if (up) begin
      if (tens == MAX_TENS && units == MAX_UNITS) begin
        step_tens  = 4'd0;
        step_units = 4'd0;
        step_wrap  = 1'b1;
      end else if (units == 4'd9) begin
        step_units = 4'd0;
        step_tens  = tens + 4'd1;
      end else begin
        step_units = units + 4'd1;
      end
    end else begin
      if (tens == 4'd0 && units == 4'd0) begin
        step_tens  = MAX_TENS;
        step_units = MAX_UNITS;
        step_wrap  = 1'b1;
      end else if (units == 4'd0) begin
        step_units = 4'd9;
        step_tens  = tens - 4'd1;
      end else begin
        step_units = units - 4'd1;
      end
    end
  end

  always_comb begin
    load_value = 8'(load_tens) * 8'd10 + 8'(load_units);
    load_valid = (load_tens <= 4'd9) && (load_units <= 4'd9) && (load_value < MOD_VAL);
  end

  // Count state; pulses default low and are raised only on the qualifying edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tens     <= 4'd0;
      units    <= 4'd0;
      prescale <= '0;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        tens     <= 4'd0;
        units    <= 4'd0;
        prescale <= '0;
      end else if (load) begin
        if (load_valid) begin
          tens     <= load_tens;
          units    <= load_units;
          prescale <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (!enable_n) begin
        if (prescale == PRE_LAST) begin
          prescale <= '0;
          tens     <= step_tens;
          units    <= step_units;
          carry    <= step_wrap;
        end else begin
          prescale <= prescale + PRE_W'(1);
        end
      end
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Display drive follows the registered digits with no added latency
  always_comb begin
    seg_tens  = seg_decode(tens);
    seg_units = seg_decode(units);
    if (SEG_ACTIVE_LOW) begin
      seg_tens  = ~seg_tens;
      seg_units = ~seg_units;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter_7seg.sv
// Bench for bcd_mod_counter_7seg: three configurations share stimulus and are
// compared every cycle with an integer-valued model, plus directed vectors.
module tb_bcd_mod_counter_7seg;

  localparam int NI = 3;
  localparam int          MODS [NI] = '{60, 24, 100};
  localparam int          PRES [NI] = '{1, 4, 1};
  localparam bit          SAL  [NI] = '{1'b1, 1'b0, 1'b1};
  localparam logic [6:0]  SEGS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk;
  logic       reset_n;
  logic       enable_n;
  logic       up;
  logic       clear;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_units;
  logic [3:0] tens_o  [NI];
  logic [3:0] units_o [NI];
  logic       carry_o [NI];
  logic       err_o   [NI];
  logic [6:0] segt_o  [NI];
  logic [6:0] segu_o  [NI];

  int checks   = 0;
  int failures = 0;

  int mval   [NI];
  int mpre   [NI];
  int mcarry [NI];
  int merr   [NI];

  bcd_mod_counter_7seg #(.MODULUS(60), .PRESCALE(1), .SEG_ACTIVE_LOW(1'b1)) u_m60 (
    .clk(clk), .reset_n(reset_n), .enable_n(enable_n), .up(up), .clear(clear),
    .load(load), .load_tens(load_tens), .load_units(load_units),
    .tens(tens_o[0]), .units(units_o[0]), .carry(carry_o[0]), .load_err(err_o[0]),
    .seg_tens(segt_o[0]), .seg_units(segu_o[0]));

  bcd_mod_counter_7seg #(.MODULUS(24), .PRESCALE(4), .SEG_ACTIVE_LOW(1'b0)) u_m24 (
    .clk(clk), .reset_n(reset_n), .enable_n(enable_n), .up(up), .clear(clear),
    .load(load), .load_tens(load_tens), .load_units(load_units),
    .tens(tens_o[1]), .units(units_o[1]), .carry(carry_o[1]), .load_err(err_o[1]),
    .seg_tens(segt_o[1]), .seg_units(segu_o[1]));

  bcd_mod_counter_7seg #(.MODULUS(100), .PRESCALE(1), .SEG_ACTIVE_LOW(1'b1)) u_m100 (
    .clk(clk), .reset_n(reset_n), .enable_n(enable_n), .up(up), .clear(clear),
    .load(load), .load_tens(load_tens), .load_units(load_units),
    .tens(tens_o[2]), .units(units_o[2]), .carry(carry_o[2]), .load_err(err_o[2]),
    .seg_tens(segt_o[2]), .seg_units(segu_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mval[i] = 0; mpre[i] = 0; mcarry[i] = 0; merr[i] = 0;
    end
  endtask

  // Counter value kept as a plain integer in 0..MODULUS-1
  task automatic model_edge(input bit c, input bit l, input int lt, input int lu,
                            input bit en_n, input bit u);
    for (int i = 0; i < NI; i++) begin
      mcarry[i] = 0;
      merr[i]   = 0;
      if (c) begin
        mval[i] = 0; mpre[i] = 0;
      end else if (l) begin
        if (lt <= 9 && lu <= 9 && lt * 10 + lu < MODS[i]) begin
          mval[i] = lt * 10 + lu; mpre[i] = 0;
        end else begin
          merr[i] = 1;
        end
      end else if (!en_n) begin
        mpre[i]++;
        if (mpre[i] == PRES[i]) begin
          mpre[i] = 0;
          if (u) begin
            mcarry[i] = (mval[i] == MODS[i] - 1) ? 1 : 0;
            mval[i]   = (mval[i] + 1) % MODS[i];
          end else begin
            mcarry[i] = (mval[i] == 0) ? 1 : 0;
            mval[i]   = (mval[i] + MODS[i] - 1) % MODS[i];
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [6:0] et7, eu7;
    for (int i = 0; i < NI; i++) begin
      et7 = SEGS[mval[i] / 10];
      eu7 = SEGS[mval[i] % 10];
      if (SAL[i]) begin
        et7 = ~et7; eu7 = ~eu7;
      end
      chk($sformatf("%s.tens[%0d]", tag, i), int'(tens_o[i]), mval[i] / 10);
      chk($sformatf("%s.units[%0d]", tag, i), int'(units_o[i]), mval[i] % 10);
      chk($sformatf("%s.carry[%0d]", tag, i), int'(carry_o[i]), mcarry[i]);
      chk($sformatf("%s.load_err[%0d]", tag, i), int'(err_o[i]), merr[i]);
      chk($sformatf("%s.seg_tens[%0d]", tag, i), int'(segt_o[i]), int'(et7));
      chk($sformatf("%s.seg_units[%0d]", tag, i), int'(segu_o[i]), int'(eu7));
    end
  endtask

  task automatic cycle(input bit c, input bit l, input int lt, input int lu,
                       input bit en_n, input bit u, input string tag);
    clear      = c;
    load       = l;
    load_tens  = 4'(lt);
    load_units = 4'(lu);
    enable_n   = en_n;
    up         = u;
    @(posedge clk);
    model_edge(c, l, lt, lu, en_n, u);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse between edges, held across one edge
  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk({tag, ".async_tens"}, int'(tens_o[0]), 0);
    chk({tag, ".async_units"}, int'(units_o[0]), 0);
    chk({tag, ".async_carry"}, int'(carry_o[0]), 0);
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    #2;
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit clr; bit ld; int lt; int lu; bit en_n; bit u;
    int et; int eu; int ec; int ee;
  } vec_t;

  vec_t vecs [20];

  initial begin
    // Hand-derived expectations for the MODULUS=60, PRESCALE=1 instance
    vecs[0]  = '{1, 0, 0, 0,  1, 1, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 5, 8,  1, 1, 5, 8, 0, 0};
    vecs[2]  = '{0, 0, 0, 0,  0, 1, 5, 9, 0, 0};
    vecs[3]  = '{0, 0, 0, 0,  0, 1, 0, 0, 1, 0};
    vecs[4]  = '{0, 0, 0, 0,  0, 1, 0, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0,  0, 0, 5, 9, 1, 0};
    vecs[7]  = '{0, 0, 0, 0,  0, 0, 5, 8, 0, 0};
    vecs[8]  = '{0, 1, 1, 0,  1, 0, 1, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 0,  0, 0, 0, 9, 0, 0};
    vecs[10] = '{0, 1, 6, 0,  1, 1, 0, 9, 0, 1};
    vecs[11] = '{0, 0, 0, 0,  1, 1, 0, 9, 0, 0};
    vecs[12] = '{0, 1, 2, 10, 1, 1, 0, 9, 0, 1};
    vecs[13] = '{0, 1, 4, 5,  1, 1, 4, 5, 0, 0};
    vecs[14] = '{0, 1, 4, 5,  0, 1, 4, 5, 0, 0};
    vecs[15] = '{0, 1, 3, 3,  1, 1, 3, 3, 0, 0};
    vecs[16] = '{1, 1, 1, 2,  1, 1, 0, 0, 0, 0};
    vecs[17] = '{0, 1, 5, 9,  1, 1, 5, 9, 0, 0};
    vecs[18] = '{1, 0, 0, 0,  0, 1, 0, 0, 0, 0};
    vecs[19] = '{0, 0, 0, 0,  0, 0, 5, 9, 1, 0};

    reset_n = 1'b0; enable_n = 1'b1; up = 1'b1; clear = 1'b0; load = 1'b0;
    load_tens = 4'd0; load_units = 4'd0;
    model_reset();
    #12;
    chk("reset.seg_tens0", int'(segt_o[0]), 'h40);
    chk("reset.seg_units0", int'(segu_o[0]), 'h40);
    chk("reset.seg_tens1", int'(segt_o[1]), 'h3F);
    check_all("reset");
    reset_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      cycle(vecs[k].clr, vecs[k].ld, vecs[k].lt, vecs[k].lu, vecs[k].en_n, vecs[k].u,
            $sformatf("vec%0d", k));
      chk($sformatf("vec%0d.tens", k), int'(tens_o[0]), vecs[k].et);
      chk($sformatf("vec%0d.units", k), int'(units_o[0]), vecs[k].eu);
      chk($sformatf("vec%0d.carry", k), int'(carry_o[0]), vecs[k].ec);
      chk($sformatf("vec%0d.load_err", k), int'(err_o[0]), vecs[k].ee);
    end

    // Reset mid-count at 37, then count up from 00
    cycle(0, 1, 3, 6, 1, 1, "pre37");
    cycle(0, 0, 0, 0, 0, 1, "at37");
    chk("at37.value", int'(tens_o[0]) * 10 + int'(units_o[0]), 37);
    do_reset("rst37");
    chk("rst37.seg_tens0", int'(segt_o[0]), 'h40);
    chk("rst37.seg_units0", int'(segu_o[0]), 'h40);
    for (int k = 1; k <= 10; k++) begin
      cycle(0, 0, 0, 0, 0, 1, $sformatf("cnt%0d", k));
      chk($sformatf("cnt%0d.tens", k), int'(tens_o[0]), k / 10);
      chk($sformatf("cnt%0d.units", k), int'(units_o[0]), k % 10);
      if (k == 7) chk("cnt7.seg_units", int'(segu_o[0]), 'h78);
    end

    // MODULUS=24 wrap with PRESCALE=4
    cycle(0, 1, 2, 3, 1, 1, "ld23");
    for (int k = 1; k <= 4; k++) begin
      cycle(0, 0, 0, 0, 0, 1, $sformatf("w24_%0d", k));
      chk($sformatf("w24_%0d.value", k), int'(tens_o[1]) * 10 + int'(units_o[1]),
          (k < 4) ? 23 : 0);
      chk($sformatf("w24_%0d.carry", k), int'(carry_o[1]), (k < 4) ? 0 : 1);
    end
    cycle(0, 0, 0, 0, 1, 1, "w24_after");
    chk("w24_after.carry", int'(carry_o[1]), 0);

    // MODULUS=100: 99 -> 00
    cycle(0, 1, 9, 9, 1, 1, "ld99");
    chk("ld99.err_m60", int'(err_o[0]), 1);
    cycle(0, 0, 0, 0, 0, 1, "w100");
    chk("w100.value", int'(tens_o[2]) * 10 + int'(units_o[2]), 0);
    chk("w100.carry", int'(carry_o[2]), 1);

    // Prescaler: step every 4th enabled edge, hold delays by the hold length
    cycle(1, 0, 0, 0, 1, 1, "pclr");
    for (int k = 1; k <= 8; k++) begin
      cycle(0, 0, 0, 0, 0, 1, $sformatf("pre%0d", k));
      chk($sformatf("pre%0d.units", k), int'(units_o[1]), k / 4);
    end
    cycle(1, 0, 0, 0, 1, 1, "hclr");
    cycle(0, 0, 0, 0, 0, 1, "h1");
    cycle(0, 0, 0, 0, 0, 1, "h2");
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 1, 1, $sformatf("hold%0d", k));
    cycle(0, 0, 0, 0, 0, 1, "h3");
    chk("h3.units", int'(units_o[1]), 0);
    cycle(0, 0, 0, 0, 0, 1, "h4");
    chk("h4.units", int'(units_o[1]), 1);
    for (int k = 0; k < 20; k++) cycle(0, 0, 0, 0, 1, $urandom_range(0, 1), "idle");
    chk("idle.units", int'(units_o[1]), 1);

    // Randomised traffic against the model
    begin
      bit rc, rl, ren, ru;
      ru = 1'b1;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 299) == 0) do_reset($sformatf("rrst%0d", n));
        rc  = ($urandom_range(0, 24) == 0);
        rl  = ($urandom_range(0, 9) == 0);
        ren = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 15) == 0) ru = ~ru;
        cycle(rc, rl, $urandom_range(0, 11), $urandom_range(0, 11), ren, ru,
              $sformatf("rnd%0d", n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
